// File: rtl/eth_rx_fcs_check_if.sv
// Byte-stream bundle for the Ethernet receive FCS checker: GMII-style receive side in,
// FCS-stripped payload plus a per-frame verdict out.
interface eth_rx_fcs_check_if #(
    parameter int LEN_W = 11
) ();
    logic             rx_dv;
    logic             rx_er;
    logic [7:0]       rx_data;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             frame_done;
    logic             frame_ok;
    logic [LEN_W-1:0] frame_len;

    // master: the receive front end feeding the checker and consuming its results
    modport master (
        output rx_dv, rx_er, rx_data,
        input  out_valid, out_data, frame_done, frame_ok, frame_len
    );

    modport slave (
        input  rx_dv, rx_er, rx_data,
        output out_valid, out_data, frame_done, frame_ok, frame_len
    );
endinterface

// File: rtl/eth_rx_fcs_check.sv
// Ethernet receive FCS checker: strips preamble/SFD, forwards payload without its FCS and
// issues a one-cycle good/bad verdict per frame. Define RX_FCS_STATS_EN for good/bad frame counters.
module eth_rx_fcs_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 11
) (
    input  logic              clock,
    input  logic              reset,
    eth_rx_fcs_check_if.slave bus
`ifdef RX_FCS_STATS_EN
    ,
    input  logic              stats_clear,
    output logic [15:0]       good_cnt,
    output logic [15:0]       bad_cnt
`endif
);

    localparam int               DATA_W      = 8;
    localparam logic [DATA_W-1:0] PRE_BYTE   = 8'h55;
    localparam logic [DATA_W-1:0] SFD_BYTE   = 8'hD5;
    localparam logic [31:0]      CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0]      CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [LEN_W-1:0] CNT_SAT     = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] FCS_BYTES   = LEN_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } state_t;

    // Reflected CRC-32, one byte per call, data LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [DATA_W-1:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < DATA_W; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

    // Payload length floors at zero for frames shorter than the FCS itself.
    function automatic logic [LEN_W-1:0] payload_len(input logic [LEN_W-1:0] total);
        return (total < FCS_BYTES) ? '0 : total - FCS_BYTES;
    endfunction

    function automatic logic len_in_range(input logic [LEN_W-1:0] total);
        return (int'(total) >= MIN_LEN) && (int'(total) <= MAX_LEN);
    endfunction

    state_t state, state_nxt;
    logic   start_frame, take_byte, end_frame;

    logic [31:0]       crc_p0;
    logic [LEN_W-1:0]  cnt_p0;
    logic              err_p0;
    logic [DATA_W-1:0] dly_p0, dly_p1, dly_p2, dly_p3;

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              done_p1;
    logic              ok_p1;
    logic [LEN_W-1:0]  len_p1;

    logic              out_en;
    logic              verdict_ok;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        take_byte   = 1'b0;
        end_frame   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.rx_dv) state_nxt = (bus.rx_data == PRE_BYTE) ? ST_PRE : ST_DROP;
            end
            ST_PRE: begin
                if (!bus.rx_dv) begin
                    state_nxt = ST_IDLE;
                end else if (bus.rx_data == SFD_BYTE) begin
                    state_nxt   = ST_DATA;
                    start_frame = 1'b1;
                end else if (bus.rx_data != PRE_BYTE) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DATA: begin
                if (bus.rx_dv) begin
                    take_byte = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                    end_frame = 1'b1;
                end
            end
            ST_DROP: begin
                if (!bus.rx_dv) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A byte leaves the delay line once four newer bytes exist behind it; frames that
    // run past MAX_LEN stop producing output.
    assign out_en     = take_byte && (cnt_p0 >= FCS_BYTES) && (int'(cnt_p0) < MAX_LEN);
    assign verdict_ok = (crc_p0 == CRC_RESIDUE) && len_in_range(cnt_p0) && !(err_p0 || bus.rx_er);

    // Stage p0: CRC accumulation, byte count and 4-byte FCS delay line
    always_ff @(posedge clock) begin
        if (reset) begin
            crc_p0 <= '0;
            cnt_p0 <= '0;
            err_p0 <= 1'b0;
            dly_p0 <= '0;
            dly_p1 <= '0;
            dly_p2 <= '0;
            dly_p3 <= '0;
        end else if (start_frame) begin
            crc_p0 <= CRC_INIT;
            cnt_p0 <= '0;
            err_p0 <= 1'b0;
        end else if (take_byte) begin
            crc_p0 <= crc32_byte(crc_p0, bus.rx_data);
            if (cnt_p0 != CNT_SAT) cnt_p0 <= cnt_p0 + LEN_W'(1);
            if (bus.rx_er) err_p0 <= 1'b1;
            dly_p0 <= bus.rx_data;
            dly_p1 <= dly_p0;
            dly_p2 <= dly_p1;
            dly_p3 <= dly_p2;
        end
    end

    // Stage p1: registered payload byte and frame verdict
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            done_p1 <= 1'b0;
            ok_p1   <= 1'b0;
            len_p1  <= '0;
        end else begin
            vld_p1  <= out_en;
            done_p1 <= end_frame;
            ok_p1   <= end_frame && verdict_ok;
            len_p1  <= end_frame ? payload_len(cnt_p0) : '0;
            if (out_en) data_p1 <= dly_p3;
        end
    end

    assign bus.out_valid  = vld_p1;
    assign bus.out_data   = data_p1;
    assign bus.frame_done = done_p1;
    assign bus.frame_ok   = ok_p1;
    assign bus.frame_len  = len_p1;

`ifdef RX_FCS_STATS_EN
    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clock) begin
        if (reset || stats_clear) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (done_p1) begin
            if (ok_p1) begin
                if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
            end else begin
                if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Bench for eth_rx_fcs_check: two instances (MIN_LEN=0 and default) share one stimulus
// stream; a table of frames plus hand-written drop/reset sequences feed a queue scoreboard.
module tb_eth_rx_fcs_check;
    localparam int MAX_LEN = 1518;
    localparam int LEN_W   = 11;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_dv, rx_er;
    logic [7:0] rx_data;
    bit         mon_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    eth_rx_fcs_check_if #(.LEN_W(LEN_W)) bus_a ();
    eth_rx_fcs_check_if #(.LEN_W(LEN_W)) bus_b ();

    assign bus_a.rx_dv   = rx_dv;
    assign bus_a.rx_er   = rx_er;
    assign bus_a.rx_data = rx_data;
    assign bus_b.rx_dv   = rx_dv;
    assign bus_b.rx_er   = rx_er;
    assign bus_b.rx_data = rx_data;

`ifdef RX_FCS_STATS_EN
    logic        stats_clear;
    logic [15:0] good_a, bad_a, good_b, bad_b;
`endif

    eth_rx_fcs_check #(.MIN_LEN(0), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
`ifdef RX_FCS_STATS_EN
        ,
        .stats_clear (stats_clear),
        .good_cnt    (good_a),
        .bad_cnt     (bad_a)
`endif
    );

    eth_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
`ifdef RX_FCS_STATS_EN
        ,
        .stats_clear (stats_clear),
        .good_cnt    (good_b),
        .bad_cnt     (bad_b)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic             ok;
        logic [LEN_W-1:0] len;
    } verd_t;

    typedef struct {
        int n_tot;
        bit use_123;
        bit bad_fcs;
        int er_at;
        bit ok_a;
        bit ok_b;
        int exp_len;
    } vec_t;

    logic [7:0] pay_a[$];
    logic [7:0] pay_b[$];
    verd_t      ver_a[$];
    verd_t      ver_b[$];
    verd_t      va, vb;
    vec_t       vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++)
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic cyc(input logic dv, input logic er, input logic [7:0] d);
        @(posedge clock);
        #1;
        rx_dv   = dv;
        rx_er   = er;
        rx_data = d;
    endtask

    task automatic send_frame(input vec_t v);
        logic [7:0]  fr[$];
        logic [7:0]  b;
        logic [31:0] c;
        int          n_out;
        if (v.use_123) begin
            for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
            fr.push_back(8'h26);
            fr.push_back(8'h39);
            fr.push_back(8'hF4);
            fr.push_back(v.bad_fcs ? 8'hCA : 8'hCB);
        end else if (v.n_tot >= 4) begin
            c = 32'hFFFFFFFF;
            for (int i = 0; i < v.n_tot - 4; i++) begin
                b = 8'(i * 37 + 11 + v.n_tot);
                fr.push_back(b);
                c = crc_byte(c, b);
            end
            c = ~c;
            for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
            if (v.bad_fcs) fr[fr.size() - 1] = fr[fr.size() - 1] ^ 8'h01;
        end else begin
            for (int i = 0; i < v.n_tot; i++) fr.push_back(8'(i * 7 + 3));
        end
        n_out = (v.n_tot < 4) ? 0 : v.n_tot - 4;
        if (n_out > MAX_LEN - 4) n_out = MAX_LEN - 4;
        for (int i = 0; i < n_out; i++) begin
            pay_a.push_back(fr[i]);
            pay_b.push_back(fr[i]);
        end
        ver_a.push_back('{ok: v.ok_a, len: LEN_W'(v.exp_len)});
        ver_b.push_back('{ok: v.ok_b, len: LEN_W'(v.exp_len)});
        repeat (7) cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < fr.size(); i++) cyc(1'b1, (i == v.er_at), fr[i]);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (bus_a.out_valid) begin
                if (pay_a.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL a_unexpected_payload: got byte %0h expected no output", bus_a.out_data);
                end else check("a_payload", bus_a.out_data, pay_a.pop_front());
            end
            if (bus_a.frame_done) begin
                if (ver_a.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL a_unexpected_done: got frame_done=1 expected 0");
                end else begin
                    va = ver_a.pop_front();
                    check("a_frame_ok", bus_a.frame_ok, va.ok);
                    check("a_frame_len", bus_a.frame_len, va.len);
                end
            end else check("a_verdict_idle", {bus_a.frame_ok, bus_a.frame_len}, 0);

            if (bus_b.out_valid) begin
                if (pay_b.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL b_unexpected_payload: got byte %0h expected no output", bus_b.out_data);
                end else check("b_payload", bus_b.out_data, pay_b.pop_front());
            end
            if (bus_b.frame_done) begin
                if (ver_b.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL b_unexpected_done: got frame_done=1 expected 0");
                end else begin
                    vb = ver_b.pop_front();
                    check("b_frame_ok", bus_b.frame_ok, vb.ok);
                    check("b_frame_len", bus_b.frame_len, vb.len);
                end
            end else check("b_verdict_idle", {bus_b.frame_ok, bus_b.frame_len}, 0);
        end
    end

    initial begin
        reset   = 1'b1;
        rx_dv   = 1'b0;
        rx_er   = 1'b0;
        rx_data = 8'h00;
`ifdef RX_FCS_STATS_EN
        stats_clear = 1'b0;
`endif
        //           n_tot 123 bad  er  okA okB  len
        vecs[0]  = '{13,   1,  0,  -1,  1,  0,   9};
        vecs[1]  = '{13,   1,  1,  -1,  0,  0,   9};
        vecs[2]  = '{20,   0,  0,  -1,  1,  0,  16};
        vecs[3]  = '{64,   0,  0,  -1,  1,  1,  60};
        vecs[4]  = '{64,   0,  0,  30,  0,  0,  60};
        vecs[5]  = '{64,   0,  0,  -1,  1,  1,  60};
        vecs[6]  = '{0,    0,  0,  -1,  0,  0,   0};
        vecs[7]  = '{3,    0,  0,  -1,  0,  0,   0};
        vecs[8]  = '{63,   0,  0,  -1,  1,  0,  59};
        vecs[9]  = '{1518, 0,  0,  -1,  1,  1, 1514};
        vecs[10] = '{1519, 0,  0,  -1,  0,  0, 1515};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_a_out", {bus_a.out_valid, bus_a.out_data, bus_a.frame_done, bus_a.frame_ok, bus_a.frame_len}, 0);
        check("rst_b_out", {bus_b.out_valid, bus_b.out_data, bus_b.frame_done, bus_b.frame_ok, bus_b.frame_len}, 0);
        mon_en = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < 6; i++) send_frame(vecs[i]);

        // Bad preamble: everything until rx_dv falls is discarded, even a later SFD.
        cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 8'h13);
        cyc(1'b1, 1'b0, 8'hD5);
        cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 8'hAA);
        cyc(1'b0, 1'b0, 8'h00);
        @(negedge clock);
        check("drop_a_quiet", {bus_a.out_valid, bus_a.frame_done}, 0);
        check("drop_b_quiet", {bus_b.out_valid, bus_b.frame_done}, 0);
        send_frame(vecs[3]);

        for (int i = 6; i < 11; i++) send_frame(vecs[i]);

        // Reset pulse mid-frame: bytes 0..5 already emerged, the rest is dropped.
        for (int i = 0; i < 6; i++) begin
            pay_a.push_back(8'h40 + 8'(i));
            pay_b.push_back(8'h40 + 8'(i));
        end
        repeat (7) cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'h40 + 8'(i));
        cyc(1'b1, 1'b0, 8'h77);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        rx_data = 8'h88;
        @(negedge clock);
        check("midrst_a_out", {bus_a.out_valid, bus_a.out_data, bus_a.frame_done, bus_a.frame_ok, bus_a.frame_len}, 0);
        check("midrst_b_out", {bus_b.out_valid, bus_b.out_data, bus_b.frame_done, bus_b.frame_ok, bus_b.frame_len}, 0);
        repeat (3) cyc(1'b1, 1'b0, 8'h99);
        cyc(1'b1, 1'b0, 8'h26);
        cyc(1'b0, 1'b0, 8'h00);
        send_frame(vecs[5]);

`ifdef RX_FCS_STATS_EN
        @(posedge clock);
        #1 stats_clear = 1'b1;
        @(posedge clock);
        #1 stats_clear = 1'b0;
        @(negedge clock);
        check("stats_pre_clear", {good_b, bad_b}, 0);
        send_frame(vecs[3]);
        send_frame(vecs[3]);
        send_frame(vecs[1]);
        repeat (4) cyc(1'b0, 1'b0, 8'h00);
        @(negedge clock);
        check("stats_a_good", good_a, 2);
        check("stats_a_bad", bad_a, 1);
        check("stats_b_good", good_b, 2);
        check("stats_b_bad", bad_b, 1);
        @(posedge clock);
        #1 stats_clear = 1'b1;
        @(posedge clock);
        #1 stats_clear = 1'b0;
        @(negedge clock);
        check("stats_a_cleared", {good_a, bad_a}, 0);
        check("stats_b_cleared", {good_b, bad_b}, 0);
`endif

        for (int i = 0; i < 50; i++) begin
            if (pay_a.size() == 0 && pay_b.size() == 0 && ver_a.size() == 0 && ver_b.size() == 0) break;
            @(posedge clock);
        end
        repeat (3) @(posedge clock);
        check("drain_pay_a", pay_a.size(), 0);
        check("drain_pay_b", pay_b.size(), 0);
        check("drain_ver_a", ver_a.size(), 0);
        check("drain_ver_b", ver_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
